// File: rtl/eea_inv_pkg.sv
// Shared types and constants for the extended-Euclidean GF(2^M) inverter controller.
package eea_inv_pkg;

    localparam int unsigned DEFAULT_M = 8;

    // x^8 + x^4 + x^3 + x + 1, bits 0..M of the default modulus
    localparam logic [DEFAULT_M:0] FIELD_POLY = 9'h11B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width able to hold 0..2M without wrap; used for both delta and the step counter
    function automatic int unsigned ctrl_width(input int unsigned m);
        return $clog2(2 * m + 1);
    endfunction

endpackage

// File: rtl/eea_inv_if.sv
// Host/array handshake and D-cell control lines of the inverter controller.
interface eea_inv_if;

    logic start;
    logic op_zero;
    logic r_msb;
    logic s_msb;
    logic load;
    logic step_en;
    logic switch;
    logic reduce;
    logic mult_r;
    logic u_div_x;
    logic busy;
    logic done;
    logic err;

    modport master (
        output start, op_zero, r_msb, s_msb,
        input  load, step_en, switch, reduce, mult_r, u_div_x, busy, done, err
    );

    modport slave (
        input  start, op_zero, r_msb, s_msb,
        output load, step_en, switch, reduce, mult_r, u_div_x, busy, done, err
    );

endinterface

// File: rtl/eea_delta_unit.sv
// Degree-difference register and the per-step D-cell / U-V control equations.
module eea_delta_unit
    import eea_inv_pkg::*;
#(
    parameter int unsigned M  = DEFAULT_M,
    parameter int unsigned DW = ctrl_width(M)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic r_msb,
    input  logic s_msb,
    output logic switch_c,
    output logic reduce_c,
    output logic mult_r_c,
    output logic u_div_x_c
);

    localparam int unsigned DELTA_MAX = 2 * M;

    logic [DW-1:0] delta;
    logic [DW-1:0] delta_nx;
    logic          zero_c;

    assign zero_c = (delta == '0);

    // Control lines are only live while stepping so the array holds otherwise
    assign mult_r_c  = en & ~r_msb;
    assign reduce_c  = en & r_msb & s_msb;
    assign switch_c  = en & r_msb & zero_c;
    assign u_div_x_c = en & r_msb & ~zero_c;

    always_comb begin
        delta_nx = delta;
        if (clr) begin
            delta_nx = '0;
        end else if (en) begin
            if (!r_msb) begin
                // Saturate rather than wrap if the array feeds an impossible sequence
                delta_nx = (delta >= DW'(DELTA_MAX)) ? DW'(DELTA_MAX) : delta + DW'(1);
            end else if (zero_c) begin
                delta_nx = DW'(1);
            end else begin
                delta_nx = delta - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta <= '0;
        end else begin
            delta <= delta_nx;
        end
    end

endmodule

// File: rtl/eea_inv_ctrl.sv
// Sequencing FSM and step counter for the GF(2^M) extended-Euclidean inverter array.
module eea_inv_ctrl
    import eea_inv_pkg::*;
#(
    parameter int unsigned M = DEFAULT_M
) (
    input  logic        clk,
    input  logic        rst,
    eea_inv_if.slave    bus
);

    localparam int unsigned DW        = ctrl_width(M);
    localparam int unsigned CW        = ctrl_width(M);
    localparam int unsigned LAST_STEP = 2 * M - 1;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          err_nx;

    logic load_q;
    logic step_en_q;
    logic busy_q;
    logic done_q;
    logic err_q;

    logic run_c;
    logic clr_c;

    assign run_c = (state == RUN);
    assign clr_c = (state == LOAD);

    // Next-state and step-count logic
    always_comb begin
        state_nx = state;
        count_nx = count;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op_zero) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                count_nx = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (count == CW'(LAST_STEP)) begin
                    count_nx = '0;
                    state_nx = DONE;
                end else begin
                    count_nx = count + CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register; handshake outputs are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            load_q    <= 1'b0;
            step_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            load_q    <= (state_nx == LOAD);
            step_en_q <= (state_nx == RUN);
            busy_q    <= (state_nx != IDLE);
            done_q    <= (state_nx == DONE);
            err_q     <= err_nx;
        end
    end

    eea_delta_unit #(
        .M  (M),
        .DW (DW)
    ) u_delta (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_c),
        .en        (run_c),
        .r_msb     (bus.r_msb),
        .s_msb     (bus.s_msb),
        .switch_c  (bus.switch),
        .reduce_c  (bus.reduce),
        .mult_r_c  (bus.mult_r),
        .u_div_x_c (bus.u_div_x)
    );

    assign bus.load    = load_q;
    assign bus.step_en = step_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_eea_inv_ctrl.sv
// Bench for eea_inv_ctrl (M=4, P=x^4+x+1) with a behavioural R/S and U/V array model.
module tb_eea_inv_ctrl;

    localparam int unsigned TM = 4;
    localparam logic [4:0]  TP = 5'b10011;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic        chk_u;
        logic [3:0]  u;
    } sb_t;

    typedef struct {
        logic [3:0] a;
        logic       zero;
        logic [3:0] exp_u;
    } op_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc_n = 0;
    int n_chk = 0;
    int n_fail = 0;
    sb_t sb[$];

    eea_inv_if bus();

    eea_inv_ctrl #(.M(TM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Behavioural array: R/S column, U/V column, obeying the controller's lines
    logic [4:0] ar = '0, as = '0;
    logic [3:0] au = '0, av = '0, a_val = '0;
    logic c_load = 0, c_step = 0, c_sw = 0, c_red = 0, c_mult = 0, c_div = 0;
    logic use_model = 1'b1, frc_r = 1'b0, frc_s = 1'b0;

    assign bus.r_msb = use_model ? ar[4] : frc_r;
    assign bus.s_msb = use_model ? as[4] : frc_s;

    function automatic logic [3:0] mulx(input logic [3:0] u);
        logic [4:0] t;
        t = {u, 1'b0};
        if (t[4]) t = t ^ TP;
        return t[3:0];
    endfunction

    function automatic logic [3:0] divx(input logic [3:0] u);
        logic [4:0] t;
        t = {1'b0, u};
        if (t[0]) t = t ^ TP;
        return t[4:1];
    endfunction

    always @(negedge clk) begin
        c_load <= bus.load;
        c_step <= bus.step_en;
        c_sw   <= bus.switch;
        c_red  <= bus.reduce;
        c_mult <= bus.mult_r;
        c_div  <= bus.u_div_x;
    end

    always @(posedge clk) begin : array_model
        logic [4:0] nr, ns, t5;
        logic [3:0] nu, nv, t4;
        nr = ar; ns = as; nu = au; nv = av;
        if (c_load) begin
            nr = {1'b0, a_val}; ns = TP; nu = 4'd1; nv = 4'd0;
        end else if (c_step) begin
            if (c_mult) begin
                nr = {ar[3:0], 1'b0};
                nu = mulx(au);
            end else begin
                if (c_red) begin
                    ns = as ^ ar;
                    nv = av ^ au;
                end
                ns = {ns[3:0], 1'b0};
                if (c_sw) begin
                    t5 = nr; nr = ns; ns = t5;
                    t4 = nu; nu = nv; nv = t4;
                    nu = mulx(nu);
                end else if (c_div) begin
                    nu = divx(nu);
                end
            end
        end
        ar <= nr; as <= ns; au <= nu; av <= nv;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest accepted start
    always @(negedge clk) begin : monitor
        sb_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc_n);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc_n, e.cyc);
                chk("done_err", 32'(bus.err), 32'(e.err));
                chk("load_with_done", 32'(bus.load), 32'd0);
                if (e.chk_u) chk("u_result", 32'(au), 32'(e.u));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] a, input logic zero, input logic chk_u,
                         input logic [3:0] exp_u);
        sb_t e;
        a_val       = a;
        bus.start   = 1'b1;
        bus.op_zero = zero;
        e.cyc   = cyc_n + (zero ? 1 : 2 * TM + 2);
        e.err   = zero;
        e.chk_u = chk_u & ~zero;
        e.u     = exp_u;
        sb.push_back(e);
    endtask

    task automatic finish_op(input string tag);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 40 cycles", tag);
            sb.delete();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load"},    32'(bus.load),    32'd0);
        chk({tag, "_step_en"}, 32'(bus.step_en), 32'd0);
        chk({tag, "_switch"},  32'(bus.switch),  32'd0);
        chk({tag, "_reduce"},  32'(bus.reduce),  32'd0);
        chk({tag, "_mult_r"},  32'(bus.mult_r),  32'd0);
        chk({tag, "_u_div_x"}, 32'(bus.u_div_x), 32'd0);
        chk({tag, "_busy"},    32'(bus.busy),    32'd0);
        chk({tag, "_done"},    32'(bus.done),    32'd0);
        chk({tag, "_err"},     32'(bus.err),     32'd0);
    endtask

    // Held r_msb/s_msb run; expected lines and delta come from an independent delta model
    task automatic run_pattern(input logic r, input logic s, input string tag);
        int unsigned d;
        use_model = 1'b0;
        frc_r = r;
        frc_s = s;
        issue(4'd0, 1'b0, 1'b0, 4'd0);
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_load"}, 32'(bus.load), 32'd1);
        chk({tag, "_load_step_en"}, 32'(bus.step_en), 32'd0);
        d = 0;
        for (int i = 0; i < 2 * TM; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("%s_step_en[%0d]", tag, i), 32'(bus.step_en), 32'd1);
            chk($sformatf("%s_mult_r[%0d]", tag, i),  32'(bus.mult_r), 32'(!r));
            chk($sformatf("%s_reduce[%0d]", tag, i),  32'(bus.reduce), 32'(r & s));
            chk($sformatf("%s_switch[%0d]", tag, i),  32'(bus.switch), 32'(r && d == 0));
            chk($sformatf("%s_u_div_x[%0d]", tag, i), 32'(bus.u_div_x), 32'(r && d != 0));
            chk($sformatf("%s_delta[%0d]", tag, i),   32'(dut.u_delta.delta), d);
            if (!r)          d = (d >= 2 * TM) ? 2 * TM : d + 1;
            else if (d == 0) d = 1;
            else             d = d - 1;
        end
        step();
        @(negedge clk);
        chk({tag, "_delta_final"}, 32'(dut.u_delta.delta), d);
        chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
        chk({tag, "_step_en_in_done"}, 32'(bus.step_en), 32'd0);
        step();
        use_model = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        op_vec_t vecs[5];
        vecs[0] = '{a: 4'b0010, zero: 1'b0, exp_u: 4'b1001};
        vecs[1] = '{a: 4'b0001, zero: 1'b0, exp_u: 4'b0001};
        vecs[2] = '{a: 4'b0011, zero: 1'b0, exp_u: 4'b1110};
        vecs[3] = '{a: 4'b0100, zero: 1'b0, exp_u: 4'b1101};
        vecs[4] = '{a: 4'b0000, zero: 1'b1, exp_u: 4'b0000};

        bus.start   = 1'b0;
        bus.op_zero = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk_idle("por");
        step();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].a, vecs[i].zero, 1'b1, vecs[i].exp_u);
            finish_op($sformatf("vec%0d", i));
        end

        run_pattern(1'b0, 1'b1, "r0");
        run_pattern(1'b1, 1'b1, "r1s1");

        // Zero operand: straight to DONE, array never touched
        issue(4'd0, 1'b1, 1'b0, 4'd0);
        step();
        bus.start   = 1'b0;
        bus.op_zero = 1'b0;
        @(negedge clk);
        chk("zero_load", 32'(bus.load), 32'd0);
        chk("zero_step_en", 32'(bus.step_en), 32'd0);
        chk("zero_busy", 32'(bus.busy), 32'd1);
        step();
        @(negedge clk);
        chk("zero_after_busy", 32'(bus.busy), 32'd0);
        step();

        // Reset during RUN step 3 aborts; next operation still completes on time
        issue(4'b0010, 1'b0, 1'b1, 4'b1001);
        step();
        bus.start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("pre_rst_step_en", 32'(bus.step_en), 32'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_idle("rst_mid1");
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_idle("rst_mid2");
        step();
        issue(4'b0010, 1'b0, 1'b1, 4'b1001);
        finish_op("post_rst");

        // start during RUN and DONE ignored; back-to-back start after DONE accepted
        issue(4'b0001, 1'b0, 1'b1, 4'b0001);
        step();
        bus.start = 1'b0;
        repeat (2) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("in_done_state", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        step();
        issue(4'b0010, 1'b0, 1'b1, 4'b1001);
        finish_op("b2b");

        repeat (4) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
